// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator stream tracker.
//   - Stats FSM states:  S_EMPTY / S_RUN
//   - Output FSM states: S_OEMPTY / S_OFULL
//   - Relation codes, one-hot {gt,lt,eq}; REL_NONE marks an empty result register
//   - Default operand and counter widths
package cmp_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } stats_state_t;

  typedef enum logic {
    S_OEMPTY = 1'b0,
    S_OFULL  = 1'b1
  } out_state_t;

  typedef enum logic [2:0] {
    REL_NONE = 3'b000,
    REL_GT   = 3'b100,
    REL_LT   = 3'b010,
    REL_EQ   = 3'b001
  } rel_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational unsigned relational comparator.
// Ports:
//   a, b  in   DATA_W  operands (unsigned)
//   gt    out  1       a > b
//   lt    out  1       a < b
//   eq    out  1       a == b
module cmp_core #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              lt,
  output logic              eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_stream_tracker.sv
// Comparator stream tracker: registers the relation of each accepted (a, b)
// pair behind a one-entry valid/ready output stage, and keeps running max/min
// of a plus per-relation event counters.
// Configuration macro: CMP_SATURATE_EN -- when defined the event counters
// saturate at all-ones; otherwise they wrap modulo 2^CNT_W.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   clear                synchronous clear of max/min/counters/stats_vld
//   in_valid, in_ready   input handshake (in_ready = !out_valid | out_ready)
//   in_a, in_b           operands
//   out_valid, out_ready output handshake
//   out_gt/out_lt/out_eq registered relation, all 0 when empty
//   max_a, min_a         running extremes of accepted a
//   stats_vld            at least one sample since reset/clear
//   gt_cnt/lt_cnt/eq_cnt per-relation counts
//
// state    | meaning
// S_EMPTY  | no sample since reset/clear, stats zero
// S_RUN    | stats track accepted samples
// S_OEMPTY | result register empty
// S_OFULL  | result register holds a result
module cmp_stream_tracker
  import cmp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_gt,
  output logic              out_lt,
  output logic              out_eq,
  output logic [DATA_W-1:0] max_a,
  output logic [DATA_W-1:0] min_a,
  output logic              stats_vld,
  output logic [CNT_W-1:0]  gt_cnt,
  output logic [CNT_W-1:0]  lt_cnt,
  output logic [CNT_W-1:0]  eq_cnt
);

  logic gt_c, lt_c, eq_c;
  logic accept;

  cmp_core #(.DATA_W(DATA_W)) u_core (
    .a  (in_a),
    .b  (in_b),
    .gt (gt_c),
    .lt (lt_c),
    .eq (eq_c)
  );

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef CMP_SATURATE_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  // ---------------- output stage ----------------
  out_state_t ostate, ostate_nxt;
  rel_t       rel_q, rel_nxt;

  assign out_valid = (ostate == S_OFULL);
  assign in_ready  = !out_valid | out_ready;
  assign accept    = in_valid & in_ready;

  assign out_gt = (rel_q == REL_GT);
  assign out_lt = (rel_q == REL_LT);
  assign out_eq = (rel_q == REL_EQ);

  always_comb begin
    ostate_nxt = ostate;
    rel_nxt    = rel_q;
    case (ostate)
      S_OEMPTY: begin
        if (accept) begin
          ostate_nxt = S_OFULL;
          rel_nxt    = rel_t'({gt_c, lt_c, eq_c});
        end
      end
      S_OFULL: begin
        // accept while full implies out_ready: reload in place
        if (accept) begin
          rel_nxt = rel_t'({gt_c, lt_c, eq_c});
        end else if (out_ready) begin
          ostate_nxt = S_OEMPTY;
          rel_nxt    = REL_NONE;
        end
      end
      default: begin
        ostate_nxt = S_OEMPTY;
        rel_nxt    = REL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ostate <= S_OEMPTY;
      rel_q  <= REL_NONE;
    end else begin
      ostate <= ostate_nxt;
      rel_q  <= rel_nxt;
    end
  end

  // ---------------- statistics ----------------
  stats_state_t         sstate, sstate_nxt;
  logic [DATA_W-1:0]    max_q, max_nxt, min_q, min_nxt;
  logic [CNT_W-1:0]     gt_q, gt_nxt, lt_q, lt_nxt, eq_q, eq_nxt;

  assign stats_vld = (sstate == S_RUN);
  assign max_a     = max_q;
  assign min_a     = min_q;
  assign gt_cnt    = gt_q;
  assign lt_cnt    = lt_q;
  assign eq_cnt    = eq_q;

  always_comb begin
    sstate_nxt = sstate;
    max_nxt    = max_q;
    min_nxt    = min_q;
    gt_nxt     = gt_q;
    lt_nxt     = lt_q;
    eq_nxt     = eq_q;

    // clear is applied first so a simultaneous accept becomes the first sample
    if (clear) begin
      sstate_nxt = S_EMPTY;
      max_nxt    = '0;
      min_nxt    = '0;
      gt_nxt     = '0;
      lt_nxt     = '0;
      eq_nxt     = '0;
    end

    if (accept) begin
      case (sstate_nxt)
        S_EMPTY: begin
          max_nxt = in_a;
          min_nxt = in_a;
        end
        default: begin
          if (in_a > max_nxt) max_nxt = in_a;
          if (in_a < min_nxt) min_nxt = in_a;
        end
      endcase
      sstate_nxt = S_RUN;
      if (gt_c) gt_nxt = cnt_inc(gt_nxt);
      if (lt_c) lt_nxt = cnt_inc(lt_nxt);
      if (eq_c) eq_nxt = cnt_inc(eq_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sstate <= S_EMPTY;
      max_q  <= '0;
      min_q  <= '0;
      gt_q   <= '0;
      lt_q   <= '0;
      eq_q   <= '0;
    end else begin
      sstate <= sstate_nxt;
      max_q  <= max_nxt;
      min_q  <= min_nxt;
      gt_q   <= gt_nxt;
      lt_q   <= lt_nxt;
      eq_q   <= eq_nxt;
    end
  end

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Scoreboard bench for cmp_stream_tracker. Two instances share the stimulus:
// dut (CNT_W=8) and dut_s (CNT_W=2, exercises counter overflow).
module tb_cmp_stream_tracker;

  localparam int DW  = 4;
  localparam int CW  = 8;
  localparam int CWS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;

  logic          in_ready, out_valid, out_gt, out_lt, out_eq, stats_vld;
  logic [DW-1:0] max_a, min_a;
  logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt;

  logic           s_in_ready, s_out_valid, s_out_gt, s_out_lt, s_out_eq, s_stats_vld;
  logic [DW-1:0]  s_max_a, s_min_a;
  logic [CWS-1:0] s_gt_cnt, s_lt_cnt, s_eq_cnt;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_lt(out_lt), .out_eq(out_eq), .max_a(max_a), .min_a(min_a),
    .stats_vld(stats_vld), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
  );

  cmp_stream_tracker #(.DATA_W(DW), .CNT_W(CWS)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_gt(s_out_gt), .out_lt(s_out_lt), .out_eq(s_out_eq), .max_a(s_max_a),
    .min_a(s_min_a), .stats_vld(s_stats_vld), .gt_cnt(s_gt_cnt), .lt_cnt(s_lt_cnt),
    .eq_cnt(s_eq_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected counter value after n true events at width w.
  function automatic int exp_cnt(input int n, input int w);
    int top;
    top = (1 << w) - 1;
`ifdef CMP_SATURATE_EN
    return (n > top) ? top : n;
`else
    return n % (1 << w);
`endif
  endfunction

  // ---------------- reference model ----------------
  logic [2:0] q[$];     // expected {gt,lt,eq} in flight
  bit  held = 0;        // result register occupied during the current cycle
  bit  have = 0;        // a sample seen since reset/clear
  int  m_max = 0, m_min = 0;
  int  n_gt = 0, n_lt = 0, n_eq = 0;

  always @(posedge clk) begin
    bit acc;
    int a, b;
    if (rst) begin
      q.delete();
      have = 0; m_max = 0; m_min = 0; n_gt = 0; n_lt = 0; n_eq = 0;
    end else begin
      acc = in_valid && (!held || out_ready);
      a = int'(in_a);
      b = int'(in_b);
      if (clear) begin
        have = 0; m_max = 0; m_min = 0; n_gt = 0; n_lt = 0; n_eq = 0;
      end
      if (acc) begin
        q.push_back({a > b, a < b, a == b});
        if (!have) begin
          m_max = a; m_min = a;
        end else begin
          if (a > m_max) m_max = a;
          if (a < m_min) m_min = a;
        end
        have = 1;
        if (a > b) n_gt++;
        else if (a < b) n_lt++;
        else n_eq++;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit ev;
    logic [2:0] r;
    ev = (q.size() != 0);
    r  = ev ? q[0] : 3'b000;
    chk("out_valid", int'(out_valid), int'(ev));
    chk("in_ready", int'(in_ready), int'(!ev || out_ready));
    chk("out_rel", int'({out_gt, out_lt, out_eq}), int'(r));
    chk("s_out_valid", int'(s_out_valid), int'(ev));
    chk("s_out_rel", int'({s_out_gt, s_out_lt, s_out_eq}), int'(r));
    chk("stats_vld", int'(stats_vld), int'(have));
    chk("max_a", int'(max_a), m_max);
    chk("min_a", int'(min_a), m_min);
    chk("gt_cnt", int'(gt_cnt), exp_cnt(n_gt, CW));
    chk("lt_cnt", int'(lt_cnt), exp_cnt(n_lt, CW));
    chk("eq_cnt", int'(eq_cnt), exp_cnt(n_eq, CW));
    chk("s_gt_cnt", int'(s_gt_cnt), exp_cnt(n_gt, CWS));
    chk("s_lt_cnt", int'(s_lt_cnt), exp_cnt(n_lt, CWS));
    chk("s_eq_cnt", int'(s_eq_cnt), exp_cnt(n_eq, CWS));
    held = ev;
    if (!rst && ev && out_ready) void'(q.pop_front());
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int b);
    in_valid = v;
    in_a     = DW'(a);
    in_b     = DW'(b);
  endtask

  initial begin
    // 1: reset held two cycles
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_stats", int'({stats_vld, max_a, min_a, gt_cnt, lt_cnt, eq_cnt}), 0);

    // 2: back-to-back stream
    out_ready = 1'b1;
    drive(1, 5, 3); step();
    @(negedge clk); chk("t2_gt", int'(out_gt), 1);
    drive(1, 2, 7); step();
    @(negedge clk); chk("t2_lt", int'(out_lt), 1);
    drive(1, 4, 4); step();
    @(negedge clk); chk("t2_eq", int'(out_eq), 1);
    drive(0, 0, 0); step();
    @(negedge clk);
    chk("t2_cnts", int'({gt_cnt, lt_cnt, eq_cnt}), int'({8'd1, 8'd1, 8'd1}));
    chk("t2_max", int'(max_a), 5);
    chk("t2_min", int'(min_a), 2);

    // 3: backpressure holds result and blocks input
    clear = 1'b1; step(); clear = 1'b0;
    out_ready = 1'b0;
    drive(1, 9, 1); step();
    drive(1, 3, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_in_ready", int'(in_ready), 0);
      chk("t3_hold_gt", int'(out_gt), 1);
      chk("t3_eq_cnt", int'(eq_cnt), 0);
      step();
    end
    out_ready = 1'b1;
    step();
    drive(0, 0, 0);
    @(negedge clk);
    chk("t3_out_eq", int'(out_eq), 1);
    chk("t3_eq_cnt1", int'(eq_cnt), 1);
    step();

    // 4: clear together with accept
    drive(1, 12, 2); step();
    clear = 1'b1; drive(1, 6, 6); step();
    clear = 1'b0; drive(0, 0, 0);
    @(negedge clk);
    chk("t4_stats_vld", int'(stats_vld), 1);
    chk("t4_maxmin", int'({max_a, min_a}), int'({4'd6, 4'd6}));
    chk("t4_cnts", int'({gt_cnt, lt_cnt, eq_cnt}), int'({8'd0, 8'd0, 8'd1}));

    // 5: counter overflow on the CNT_W=2 instance
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 8, 0); step();
    end
    drive(0, 0, 0);
    @(negedge clk);
    chk("t5_gt_cnt8", int'(gt_cnt), 5);
`ifdef CMP_SATURATE_EN
    chk("t5_gt_cnt2", int'(s_gt_cnt), 3);
`else
    chk("t5_gt_cnt2", int'(s_gt_cnt), 1);
`endif

    // 6: reset while a result is held
    out_ready = 1'b0;
    drive(1, 1, 2); step();
    drive(0, 0, 0);
    @(negedge clk); chk("t6_pre_valid", int'(out_valid), 1);
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    chk("t6_rel", int'({out_gt, out_lt, out_eq}), 0);
    chk("t6_stats", int'({stats_vld, max_a, min_a, gt_cnt, lt_cnt, eq_cnt}), 0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      int a, b;
      a = int'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, a, b);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 99) < 2);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    drive(0, 0, 0);
    clear = 1'b0; rst = 1'b0; out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("drain_valid", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
